xnor_cmp_sequencer: RTL and testbench

- Byte-serial equality/match engine shared by two requesters.
- Arbitrates round-robin between two requesters and accepts one pair of NBYTES-wide operands at a time.
- Streams the operands LSB byte first through a single shared 8-bit XNOR datapath, one byte per cycle.
- Returns a bitwise match mask, a matching-bit count and an equal flag, tagged with the requester ID.
- Sits between compare clients and the 8-bit XNOR slice, so one datapath instance serves both clients.

---
 rtl/xnor_cmp_pkg.sv | 14 +
 rtl/popcount8.sv | 15 +
 rtl/xnor8.sv | 10 +
 rtl/xnor_cmp_sequencer.sv | 157 +++++++++++++++
 tb/tb_xnor_cmp_sequencer.sv | 341 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/xnor_cmp_pkg.sv
// Shared types and constants for the byte-serial XNOR compare sequencer.
package xnor_cmp_pkg;

  localparam int unsigned NbytesDefault = 4;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StResp
  } state_e;

  typedef logic req_id_t;

endpackage

// File: rtl/popcount8.sv
// Combinational population count of one byte.
module popcount8 (
  input  logic [7:0] in,
  output logic [3:0] cnt
);

  // Sum the eight bits as 4-bit values
  always_comb begin
    cnt = 4'd0;
    for (int i = 0; i < 8; i++) begin
      cnt = cnt + {3'b000, in[i]};
    end
  end

endmodule

// File: rtl/xnor8.sv
// 8-bit bitwise XNOR slice; the single datapath shared by both requesters.
module xnor8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] y
);

  assign y = ~(a ^ b);

endmodule

// File: rtl/xnor_cmp_sequencer.sv
// Round-robin shared byte-serial XNOR compare engine for two requesters.
module xnor_cmp_sequencer
  import xnor_cmp_pkg::*;
#(
  parameter int unsigned NBYTES = NbytesDefault,
  localparam int unsigned W = 8 * NBYTES,
  localparam int unsigned CW = $clog2(W + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic [W-1:0]  req0_a,
  input  logic [W-1:0]  req0_b,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic [W-1:0]  req1_a,
  input  logic [W-1:0]  req1_b,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic          rsp_id,
  output logic [W-1:0]  rsp_mask,
  output logic [CW-1:0] rsp_count,
  output logic          rsp_equal
);

  localparam int unsigned IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  state_e        state_q, state_d;
  req_id_t       last_q, last_d;
  req_id_t       id_q, id_d;
  req_id_t       grant;
  logic [IW-1:0] idx_q, idx_d;
  logic [W-1:0]  a_q, a_d, b_q, b_d;
  logic [W-1:0]  mask_q, mask_d;
  logic [CW-1:0] count_q, count_d;
  logic          equal_q, equal_d;
  logic          valid_q, valid_d;
  logic [W-1:0]  a_shift, b_shift;
  logic [7:0]    byte_x;
  logic [3:0]    byte_pc;
  logic          accept;

  // Current byte of each operand, LSB byte first
  assign a_shift = a_q >> {idx_q, 3'b000};
  assign b_shift = b_q >> {idx_q, 3'b000};

  xnor8 u_xnor8 (
    .a (a_shift[7:0]),
    .b (b_shift[7:0]),
    .y (byte_x)
  );

  popcount8 u_popcount8 (
    .in  (byte_x),
    .cnt (byte_pc)
  );

  // Round-robin grant: a tie goes to the requester not served last
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) begin
      grant = ~last_q;
    end else if (req1_valid) begin
      grant = 1'b1;
    end
  end

  assign req0_ready = (state_q == StIdle) && (grant == 1'b0) && !rst;
  assign req1_ready = (state_q == StIdle) && (grant == 1'b1) && !rst;
  assign accept     = (req0_ready && req0_valid) || (req1_ready && req1_valid);

  // Next-state logic: capture, byte-serial accumulate, hold result
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    id_d    = id_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    mask_d  = mask_q;
    count_d = count_q;
    equal_d = equal_q;
    valid_d = valid_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          a_d     = grant ? req1_a : req0_a;
          b_d     = grant ? req1_b : req0_b;
          id_d    = grant;
          last_d  = grant;
          mask_d  = '0;
          count_d = '0;
          equal_d = 1'b0;
          idx_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        for (int unsigned i = 0; i < NBYTES; i++) begin
          if (idx_q == IW'(i)) begin
            mask_d[8*i +: 8] = byte_x;
          end
        end
        count_d = count_q + CW'(byte_pc);
        idx_d   = idx_q + 1'b1;
        if (idx_q == IW'(NBYTES - 1)) begin
          // Equal flag comes from the final count only
          equal_d = (count_d == CW'(W));
          valid_d = 1'b1;
          state_d = StResp;
        end
      end
      StResp: begin
        if (rsp_ready) begin
          valid_d = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and result registers; reset drops any in-flight operation
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      last_q  <= 1'b1;
      id_q    <= 1'b0;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      mask_q  <= '0;
      count_q <= '0;
      equal_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      id_q    <= id_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      mask_q  <= mask_d;
      count_q <= count_d;
      equal_q <= equal_d;
      valid_q <= valid_d;
    end
  end

  assign rsp_valid = valid_q;
  assign rsp_id    = id_q;
  assign rsp_mask  = mask_q;
  assign rsp_count = count_q;
  assign rsp_equal = equal_q;

endmodule

// File: tb/tb_xnor_cmp_sequencer.sv
// Randomized and directed bench for xnor_cmp_sequencer with a transaction-level model.
module tb_xnor_cmp_sequencer;

  localparam int NB = 4;
  localparam int W  = 32;
  localparam int CW = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0_valid, req0_ready, req1_valid, req1_ready;
  logic [W-1:0]  req0_a, req0_b, req1_a, req1_b;
  logic          rsp_valid, rsp_ready, rsp_id, rsp_equal;
  logic [W-1:0]  rsp_mask;
  logic [CW-1:0] rsp_count;

  // Single-byte instance
  logic       s_req0_valid, s_req0_ready, s_req1_valid, s_req1_ready;
  logic [7:0] s_req0_a, s_req0_b, s_req1_a, s_req1_b;
  logic       s_rsp_valid, s_rsp_ready, s_rsp_id, s_rsp_equal;
  logic [7:0] s_rsp_mask;
  logic [3:0] s_rsp_count;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  xnor_cmp_sequencer #(.NBYTES(NB)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_mask   (rsp_mask),
    .rsp_count  (rsp_count),
    .rsp_equal  (rsp_equal)
  );

  xnor_cmp_sequencer #(.NBYTES(1)) dut1 (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (s_req0_valid),
    .req0_ready (s_req0_ready),
    .req0_a     (s_req0_a),
    .req0_b     (s_req0_b),
    .req1_valid (s_req1_valid),
    .req1_ready (s_req1_ready),
    .req1_a     (s_req1_a),
    .req1_b     (s_req1_b),
    .rsp_valid  (s_rsp_valid),
    .rsp_ready  (s_rsp_ready),
    .rsp_id     (s_rsp_id),
    .rsp_mask   (s_rsp_mask),
    .rsp_count  (s_rsp_count),
    .rsp_equal  (s_rsp_equal)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Transaction-level model: one outstanding op, result due NB+1 cycles after accept
  int          cyc = 0;
  int          m_acc;
  logic        m_busy, m_last, m_fresh, m_id, m_equal, m_g, m_er0, m_er1, m_erv;
  logic [W-1:0] m_mask;
  int          m_count;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      check("rst_ready0", req0_ready, 0);
      check("rst_ready1", req1_ready, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_mask", rsp_mask, 0);
      check("rst_count", rsp_count, 0);
      check("rst_equal", rsp_equal, 0);
      check("rst_id", rsp_id, 0);
      m_busy  = 1'b0;
      m_last  = 1'b1;
      m_fresh = 1'b1;
    end else begin
      m_g   = (req0_valid && req1_valid) ? ~m_last : req1_valid;
      m_er0 = !m_busy && !m_g;
      m_er1 = !m_busy && m_g;
      check("ready0", req0_ready, m_er0);
      check("ready1", req1_ready, m_er1);
      m_erv = m_busy && (cyc >= m_acc + NB + 1);
      check("rsp_valid", rsp_valid, m_erv);
      if (m_erv) begin
        check("rsp_mask", rsp_mask, m_mask);
        check("rsp_count", rsp_count, m_count);
        check("rsp_equal", rsp_equal, m_equal);
        check("rsp_id", rsp_id, m_id);
      end else if (m_fresh) begin
        check("idle_mask", rsp_mask, 0);
        check("idle_count", rsp_count, 0);
        check("idle_equal", rsp_equal, 0);
      end
      if (m_erv && rsp_ready) begin
        m_busy = 1'b0;
      end else if (!m_busy && ((m_er0 && req0_valid) || (m_er1 && req1_valid))) begin
        m_busy  = 1'b1;
        m_fresh = 1'b0;
        m_last  = m_g;
        m_id    = m_g;
        m_acc   = cyc;
        m_mask  = m_g ? ~(req1_a ^ req1_b) : ~(req0_a ^ req0_b);
        m_count = $countones(m_mask);
        m_equal = (m_count == W);
      end
    end
  end

  // Directed op with hand-computed expectations; consumer always ready
  task automatic lit_op(input logic id, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] em, input int ec, input logic ee,
                        input string tag);
    logic ok;
    int   n;
    rsp_ready = 1'b1;
    if (id) begin
      req1_a = a; req1_b = b; req1_valid = 1'b1;
    end else begin
      req0_a = a; req0_b = b; req0_valid = 1'b1;
    end
    ok = 1'b0;
    n  = 0;
    while (!ok && n < 50) begin
      @(negedge clk);
      n++;
      ok = id ? (req1_valid && req1_ready) : (req0_valid && req0_ready);
    end
    check({tag, "_accept"}, ok, 1);
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    ok = 1'b0;
    n  = 0;
    while (!ok && n < 50) begin
      @(negedge clk);
      n++;
      ok = rsp_valid;
    end
    check({tag, "_latency"}, n, NB + 1);
    check({tag, "_mask"}, rsp_mask, em);
    check({tag, "_count"}, rsp_count, ec);
    check({tag, "_equal"}, rsp_equal, ee);
    check({tag, "_id"}, rsp_id, id);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rsp(input string tag);
    int n;
    n = 0;
    while (!rsp_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_rsp_seen"}, rsp_valid, 1);
  endtask

  initial begin
    logic ok;
    int   n, got, prev, lat;
    rst = 1'b1;
    req0_valid = 0; req1_valid = 0; rsp_ready = 0;
    req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;
    s_req0_valid = 0; s_req1_valid = 0; s_rsp_ready = 0;
    s_req0_a = 0; s_req0_b = 0; s_req1_a = 0; s_req1_b = 0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Equal operands, unequal operands, fully opposite operands
    lit_op(1'b0, 32'h12345678, 32'h12345678, 32'hFFFFFFFF, 32, 1'b1, "t1");
    lit_op(1'b1, 32'h000000FF, 32'h00000000, 32'hFFFFFF00, 24, 1'b0, "t2a");
    lit_op(1'b1, 32'hFFFFFFFF, 32'h00000000, 32'h00000000, 0, 1'b0, "t2b");

    // Both requesters always valid: alternation and 6-cycle issue interval
    rsp_ready = 1'b1;
    req0_a = $urandom; req0_b = $urandom; req1_a = $urandom; req1_b = $urandom;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    n = 0; got = 0; prev = -1;
    while (got < 4 && n < 100) begin
      @(negedge clk);
      n++;
      if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) begin
        check("t3_grant", req1_ready, got % 2);
        if (prev >= 0) check("t3_interval", n - prev, NB + 2);
        prev = n;
        got++;
      end
      @(posedge clk);
      #1;
      req0_a = $urandom; req0_b = $urandom; req1_a = $urandom; req1_b = $urandom;
    end
    check("t3_accepts", got, 4);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;

    // Back-pressure on the response: nothing accepted until it drains
    rsp_ready = 1'b0;
    req0_a = 32'hDEADBEEF; req0_b = 32'hDEAD0000; req0_valid = 1'b1;
    ok = 1'b0; n = 0;
    while (!ok && n < 50) begin
      @(negedge clk);
      n++;
      ok = req0_ready;
    end
    check("t4_accept", ok, 1);
    @(posedge clk);
    #1;
    req0_a = 32'h0F0F0F0F; req0_b = 32'h0F0F0F0F;
    wait_rsp("t4");
    check("t4_hold_ready0", req0_ready, 0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("t4_hold_valid", rsp_valid, 1);
      check("t4_hold_ready0", req0_ready, 0);
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    check("t4_hs_ready0", req0_ready, 0);
    @(negedge clk);
    check("t4_next_accept", req0_ready, 1);
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    wait_rsp("t4b");
    @(posedge clk);
    #1;

    // Reset while byte 2 is being processed
    req0_a = 32'h11111111; req0_b = 32'h11111111; req0_valid = 1'b1;
    ok = 1'b0; n = 0;
    while (!ok && n < 50) begin
      @(negedge clk);
      n++;
      ok = req0_ready;
    end
    check("t5_accept", ok, 1);
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("t5_async_valid", rsp_valid, 0);
    check("t5_async_mask", rsp_mask, 0);
    check("t5_async_count", rsp_count, 0);
    check("t5_async_ready0", req0_ready, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    lit_op(1'b0, 32'hA5A5A5A5, 32'h5A5A5A5A, 32'h00000000, 0, 1'b0, "t5");

    // Single-byte instance
    s_rsp_ready = 1'b1;
    s_req0_a = 8'hF0; s_req0_b = 8'hF1; s_req0_valid = 1'b1;
    ok = 1'b0; n = 0;
    while (!ok && n < 50) begin
      @(negedge clk);
      n++;
      ok = s_req0_ready;
    end
    check("t6_accept", ok, 1);
    @(posedge clk);
    #1;
    s_req0_valid = 1'b0;
    lat = 0;
    while (!s_rsp_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    check("t6_latency", lat, 2);
    check("t6_mask", s_rsp_mask, 8'hFE);
    check("t6_count", s_rsp_count, 7);
    check("t6_equal", s_rsp_equal, 0);
    @(posedge clk);
    #1;
    s_req1_a = 8'h3C; s_req1_b = 8'h3C; s_req1_valid = 1'b1;
    @(negedge clk);
    check("t6b_accept", s_req1_ready, 1);
    @(posedge clk);
    #1;
    s_req1_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("t6b_valid", s_rsp_valid, 1);
    check("t6b_mask", s_rsp_mask, 8'hFF);
    check("t6b_count", s_rsp_count, 8);
    check("t6b_equal", s_rsp_equal, 1);
    check("t6b_id", s_rsp_id, 1);
    @(posedge clk);
    #1;

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      req0_valid = ($urandom_range(0, 2) != 0);
      req1_valid = ($urandom_range(0, 2) != 0);
      rsp_ready  = ($urandom_range(0, 3) != 0);
      req0_a = $urandom;
      req0_b = ($urandom_range(0, 3) == 0) ? req0_a : $urandom;
      req1_a = $urandom;
      req1_b = ($urandom_range(0, 3) == 0) ? req1_a ^ (32'h1 << $urandom_range(0, 31)) : $urandom;
      @(posedge clk);
      #1;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready  = 1'b1;
    repeat (10) @(posedge clk);
    #1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
